// File: rtl/setup_hold_monitor.sv
// setup_hold_monitor
//   Watches a data bus and a reference clock (both already synchronous to clk)
//   and reports setup/hold style violations as records on a valid/ready port.
//
//   A setup violation is a data bit that changed fewer than SETUP_CYC cycles
//   before (or in the same cycle as) a reference rising edge. A hold violation
//   is a data bit that changes during the HOLD_CYC cycles that follow a rising
//   edge. Hold checking is compiled in only when the macro
//   SETUP_HOLD_MONITOR_HOLD_CHECK_EN is defined; otherwise no hold records are
//   produced and viol_kind is constant 0.
//
// Ports
//   clk         sampling clock, rising edge
//   rst         synchronous active-high reset
//   enable      monitoring enable (timestamp and detection run only when 1)
//   data_in     monitored data bus [DATA_W]
//   ref_in      monitored reference clock, sampled as data
//   viol_valid  record available
//   viol_ready  consumer accepts the record
//   viol_kind   0 = setup, 1 = hold
//   viol_bits   offending data bits [DATA_W]
//   viol_stamp  timestamp of the detection cycle [CNT_W]
//   viol_count  saturating count of all detected events, dropped ones included
//   overflow    sticky: an event arrived while a record was stalled
//
// Handshake: a record is held stable with viol_valid=1 until a cycle where
// viol_valid and viol_ready are both 1. An event in that same cycle replaces
// the record; an event while stalled (valid=1, ready=0) is dropped.
module setup_hold_monitor #(
  parameter int DATA_W    = 2,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ref_in,
  output logic              viol_valid,
  input  logic              viol_ready,
  output logic              viol_kind,
  output logic [DATA_W-1:0] viol_bits,
  output logic [CNT_W-1:0]  viol_stamp,
  output logic [CNT_W-1:0]  viol_count,
  output logic              overflow
);

  localparam logic [3:0] SETUP_AGE = 4'(SETUP_CYC);

  // Two sample stages: the first registers the inputs, the second holds the
  // previous sample so changes can be seen between consecutive samples.
  logic [DATA_W-1:0]      d_q, d_qq;
  logic                   r_q, r_qq;
  logic [CNT_W-1:0]       ts;
  logic [DATA_W-1:0][3:0] age;

  logic [DATA_W-1:0] chg;
  logic              rise;
  logic [DATA_W-1:0] setup_bits;
  logic [DATA_W-1:0] hold_bits;
  logic              setup_any, hold_any, evt;
  logic [DATA_W-1:0] evt_bits;
  logic              kind_q;

  assign chg  = d_q ^ d_qq;
  assign rise = r_q & ~r_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q  <= '0;
      d_qq <= '0;
      r_q  <= 1'b0;
      r_qq <= 1'b0;
      ts   <= '0;
    end else begin
      d_q  <= data_in;
      d_qq <= d_q;
      r_q  <= ref_in;
      r_qq <= r_q;
      if (enable) ts <= ts + 1'b1;
    end
  end

  // Age is 0 in the cycle a change is seen (handled combinationally through
  // chg), so the register holds the age for the following cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W; i++) begin
      if (rst)                    age[i] <= SETUP_AGE;
      else if (chg[i])            age[i] <= 4'd1;
      else if (age[i] < SETUP_AGE) age[i] <= age[i] + 4'd1;
    end
  end

  always_comb begin
    setup_bits = '0;
    for (int i = 0; i < DATA_W; i++) begin
      setup_bits[i] = rise & (chg[i] | (age[i] < SETUP_AGE));
    end
  end

`ifdef SETUP_HOLD_MONITOR_HOLD_CHECK_EN
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC);

  typedef enum logic {IDLE, HOLD_WIN} state_t;
  state_t     state, state_nxt;
  logic [3:0] hcnt, hcnt_nxt;  // index of the current window cycle, 1-based

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // A rise inside the window restarts it; changes in that same cycle are
  // reported only as setup against the new edge.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    hold_bits = '0;
    if (!enable) begin
      state_nxt = IDLE;
      hcnt_nxt  = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = HOLD_WIN;
            hcnt_nxt  = 4'd1;
          end
        end
        HOLD_WIN: begin
          if (rise) begin
            hcnt_nxt = 4'd1;
          end else begin
            hold_bits = chg;
            if (hcnt == HOLD_LAST) begin
              state_nxt = IDLE;
              hcnt_nxt  = 4'd0;
            end else begin
              hcnt_nxt = hcnt + 4'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          hcnt_nxt  = 4'd0;
        end
      endcase
    end
  end
`else
  assign hold_bits = '0;
`endif

  assign setup_any = enable & (|setup_bits);
  assign hold_any  = enable & (|hold_bits);
  assign evt       = setup_any | hold_any;
  assign evt_bits  = setup_any ? setup_bits : hold_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      viol_valid <= 1'b0;
      kind_q     <= 1'b0;
      viol_bits  <= '0;
      viol_stamp <= '0;
      viol_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (evt) begin
        if (!viol_valid || viol_ready) begin
          viol_valid <= 1'b1;
          kind_q     <= ~setup_any;
          viol_bits  <= evt_bits;
          viol_stamp <= ts;
        end else begin
          overflow <= 1'b1;
        end
        if (viol_count != '1) viol_count <= viol_count + 1'b1;
      end else if (viol_valid && viol_ready) begin
        viol_valid <= 1'b0;
      end
    end
  end

`ifdef SETUP_HOLD_MONITOR_HOLD_CHECK_EN
  assign viol_kind = kind_q;
`else
  assign viol_kind = 1'b0;
`endif

endmodule
